// File: rtl/instr_fetch_unit.sv
// Y86-style instruction fetch: reads an instruction byte-by-byte from a
// one-cycle-latency byte memory, decodes fields, and hands them off with valid/ready.
module instr_fetch_unit #(
  parameter int unsigned DATA_WID  = 64,
  parameter int unsigned ADDR_WID  = 16,
  parameter int unsigned MEM_BYTES = 1024,
  parameter bit          AUTO      = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_WID-1:0] pc_in,
  output logic                mem_rd,
  output logic [ADDR_WID-1:0] mem_addr,
  input  logic [7:0]          mem_rdata,
  output logic [3:0]          icode,
  output logic [3:0]          ifun,
  output logic [3:0]          rA,
  output logic [3:0]          rB,
  output logic [DATA_WID-1:0] valC,
  output logic [ADDR_WID-1:0] valP,
  output logic                instr_valid,
  input  logic                out_ready,
  output logic                instr_err,
  output logic                imem_err,
  output logic                busy
);

  localparam int unsigned W   = DATA_WID / 8;
  localparam int unsigned KW  = 4;
  localparam int unsigned AW1 = ADDR_WID + 1;
  localparam logic [AW1-1:0] MEM_LIM = AW1'(MEM_BYTES);

  typedef enum logic [1:0] {IDLE, RD, CAP, HOLD} state_t;

  // Total instruction length in bytes, keyed by icode.
  function automatic logic [KW-1:0] instr_len(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h6, 4'hA, 4'hB: instr_len = KW'(2);
      4'h3, 4'h4, 4'h5:       instr_len = KW'(2 + W);
      4'h7, 4'h8:             instr_len = KW'(1 + W);
      default:                instr_len = KW'(1);
    endcase
  endfunction

  function automatic logic has_regs(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: has_regs = 1'b1;
      default:                                  has_regs = 1'b0;
    endcase
  endfunction

  state_t                state, state_d;
  logic [ADDR_WID-1:0]   pc, pc_d;
  logic [KW-1:0]         k, k_d;
  logic [3:0]            icode_d, ifun_d, ra_d, rb_d;
  logic [DATA_WID-1:0]   valc_d;
  logic [ADDR_WID-1:0]   valp_d, mem_addr_d;
  logic                  valid_d, instr_err_d, imem_err_d, mem_rd_d, busy_d;
  logic [AW1-1:0]        rd_full, nxt_full;
  logic [3:0]            cap_ic;
  logic [KW-1:0]         cap_len, k_inc, vstart, vidx;

  always_comb begin
    state_d     = state;
    pc_d        = pc;
    k_d         = k;
    icode_d     = icode;
    ifun_d      = ifun;
    ra_d        = rA;
    rb_d        = rB;
    valc_d      = valC;
    valp_d      = valP;
    valid_d     = instr_valid;
    instr_err_d = instr_err;
    imem_err_d  = imem_err;
    rd_full     = AW1'(pc) + AW1'(k);
    cap_ic      = (k == '0) ? mem_rdata[7:4] : icode;
    cap_len     = instr_len(cap_ic);
    k_inc       = KW'(k + KW'(1));
    vstart      = has_regs(icode) ? KW'(2) : KW'(1);
    vidx        = KW'(k - vstart);

    case (state)
      IDLE: begin
        if (start) begin
          pc_d        = pc_in;
          k_d         = '0;
          instr_err_d = 1'b0;
          imem_err_d  = 1'b0;
          state_d     = RD;
        end
      end
      RD: begin
        if (rd_full < MEM_LIM) begin
          state_d = CAP;
        end else begin
          // Out-of-range byte: report a synthetic nop-like record with the error flag.
          imem_err_d = 1'b1;
          icode_d    = 4'h1;
          ifun_d     = 4'h0;
          ra_d       = 4'hF;
          rb_d       = 4'hF;
          valc_d     = '0;
          valp_d     = pc;
          valid_d    = 1'b1;
          state_d    = HOLD;
        end
      end
      CAP: begin
        if (k == '0) begin
          icode_d     = mem_rdata[7:4];
          ifun_d      = mem_rdata[3:0];
          ra_d        = 4'hF;
          rb_d        = 4'hF;
          valc_d      = '0;
          instr_err_d = (mem_rdata[7:4] > 4'hB);
        end else if (k == KW'(1) && has_regs(icode)) begin
          ra_d = mem_rdata[7:4];
          rb_d = mem_rdata[3:0];
        end else begin
          for (int unsigned b = 0; b < W; b++) begin
            if (vidx == KW'(b)) valc_d[8*b +: 8] = mem_rdata;
          end
        end
        k_d = k_inc;
        if (k_inc == cap_len) begin
          valp_d  = pc + ADDR_WID'(cap_len);
          valid_d = 1'b1;
          state_d = HOLD;
        end else begin
          state_d = RD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          if (AUTO && icode != 4'h0 && !instr_err && !imem_err) begin
            pc_d    = valP;
            k_d     = '0;
            state_d = RD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Read strobe is registered: issue it for the RD cycle we are about to enter.
    nxt_full   = AW1'(pc_d) + AW1'(k_d);
    mem_rd_d   = (state_d == RD) && (nxt_full < MEM_LIM);
    mem_addr_d = ADDR_WID'(nxt_full);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= '0;
      k           <= '0;
      icode       <= 4'h0;
      ifun        <= 4'h0;
      rA          <= 4'hF;
      rB          <= 4'hF;
      valC        <= '0;
      valP        <= '0;
      instr_valid <= 1'b0;
      instr_err   <= 1'b0;
      imem_err    <= 1'b0;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      k           <= k_d;
      icode       <= icode_d;
      ifun        <= ifun_d;
      rA          <= ra_d;
      rB          <= rb_d;
      valC        <= valc_d;
      valP        <= valp_d;
      instr_valid <= valid_d;
      instr_err   <= instr_err_d;
      imem_err    <= imem_err_d;
      mem_rd      <= mem_rd_d;
      mem_addr    <= mem_addr_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a 64-bit AUTO instance and a 32-bit
// non-AUTO instance, each fed by a one-cycle-latency byte memory model.
module tb_instr_fetch_unit;

  logic clk, rst;
  int   checks = 0;
  int   errors = 0;

  logic        start64, mem_rd64, ready64, valid64, ierr64, merr64, busy64;
  logic [15:0] pc_in64, mem_addr64, valp64;
  logic [7:0]  rdata64;
  logic [3:0]  icode64, ifun64, ra64, rb64;
  logic [63:0] valc64;

  logic        start32, mem_rd32, ready32, valid32, ierr32, merr32, busy32;
  logic [15:0] pc_in32, mem_addr32, valp32;
  logic [7:0]  rdata32;
  logic [3:0]  icode32, ifun32, ra32, rb32;
  logic [31:0] valc32;

  logic [7:0] mem64 [0:1023];
  logic [7:0] mem32 [0:1023];
  int         oob64 = 0;

  instr_fetch_unit #(.DATA_WID(64), .ADDR_WID(16), .MEM_BYTES(1024), .AUTO(1'b1)) dut64 (
    .clk(clk), .rst(rst), .start(start64), .pc_in(pc_in64),
    .mem_rd(mem_rd64), .mem_addr(mem_addr64), .mem_rdata(rdata64),
    .icode(icode64), .ifun(ifun64), .rA(ra64), .rB(rb64), .valC(valc64), .valP(valp64),
    .instr_valid(valid64), .out_ready(ready64),
    .instr_err(ierr64), .imem_err(merr64), .busy(busy64));

  instr_fetch_unit #(.DATA_WID(32), .ADDR_WID(16), .MEM_BYTES(1024), .AUTO(1'b0)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .pc_in(pc_in32),
    .mem_rd(mem_rd32), .mem_addr(mem_addr32), .mem_rdata(rdata32),
    .icode(icode32), .ifun(ifun32), .rA(ra32), .rB(rb32), .valC(valc32), .valP(valp32),
    .instr_valid(valid32), .out_ready(ready32),
    .instr_err(ierr32), .imem_err(merr32), .busy(busy32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memories: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd64) begin
      rdata64 <= mem64[mem_addr64[9:0]];
      if (mem_addr64 >= 16'd1024) oob64 <= oob64 + 1;
    end
    if (mem_rd32) rdata32 <= mem32[mem_addr32[9:0]];
  end

  task automatic wait_valid64(input int limit);
    int cyc = 0;
    while (valid64 !== 1'b1 && cyc < limit) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (valid64 !== 1'b1) begin errors++; $display("FAIL wait_valid64: instr_valid=%b expected 1 within %0d cycles", valid64, limit); end
  endtask

  task automatic accept64();
    ready64 = 1'b1;
    @(posedge clk); #1;
    ready64 = 1'b0;
  endtask

  task automatic start_at64(input logic [15:0] pc);
    start64 = 1'b1; pc_in64 = pc;
    @(posedge clk); #1;
    start64 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start64 = 1'b1; pc_in64 = 16'd5;
    repeat (2) @(posedge clk);
    #1;
    start64 = 1'b0;
    checks++; if (busy64 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy64); end
    checks++; if (valid64 !== 1'b0 || mem_rd64 !== 1'b0) begin errors++; $display("FAIL reset_valid_rd: got %b%b expected 00", valid64, mem_rd64); end
    checks++; if ({icode64, ifun64, ra64, rb64} !== 16'h00FF) begin errors++; $display("FAIL reset_fields: got %h expected 00ff", {icode64, ifun64, ra64, rb64}); end
    checks++; if (valc64 !== 64'd0 || valp64 !== 16'd0) begin errors++; $display("FAIL reset_valc_valp: got %h %h expected 0 0", valc64, valp64); end
    checks++; if (ierr64 !== 1'b0 || merr64 !== 1'b0) begin errors++; $display("FAIL reset_errs: got %b%b expected 00", ierr64, merr64); end
    checks++; if (busy32 !== 1'b0 || valid32 !== 1'b0) begin errors++; $display("FAIL reset_dut32: got %b%b expected 00", busy32, valid32); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy64 !== 1'b0) begin errors++; $display("FAIL reset_idle_hold: busy=%b expected 0", busy64); end
  endtask

  task automatic test_irmovq();
    int cyc = 0;
    mem64[0] = 8'h30; mem64[1] = 8'hF2; mem64[2] = 8'h08;
    for (int i = 3; i < 10; i++) mem64[i] = 8'h00;
    mem64[10] = 8'h00;
    ready64 = 1'b1;
    start_at64(16'd0);
    repeat (19) @(posedge clk);
    #1;
    checks++; if (valid64 !== 1'b0) begin errors++; $display("FAIL irmovq_early: instr_valid=%b at cycle 20 expected 0", valid64); end
    @(posedge clk); #1;
    checks++; if (valid64 !== 1'b1) begin errors++; $display("FAIL irmovq_latency: instr_valid=%b at cycle 21 expected 1", valid64); end
    checks++; if ({icode64, ifun64, ra64, rb64} !== 16'h30F2) begin errors++; $display("FAIL irmovq_fields: got %h expected 30f2", {icode64, ifun64, ra64, rb64}); end
    checks++; if (valc64 !== 64'd8) begin errors++; $display("FAIL irmovq_valc: got %h expected 8", valc64); end
    checks++; if (valp64 !== 16'd10) begin errors++; $display("FAIL irmovq_valp: got %0d expected 10", valp64); end
    while (busy64 !== 1'b0 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    ready64 = 1'b0;
    checks++; if (busy64 !== 1'b0) begin errors++; $display("FAIL irmovq_halt_idle: busy=%b expected 0", busy64); end
  endtask

  task automatic test_auto_stream();
    mem64[0] = 8'h10; mem64[1] = 8'h60; mem64[2] = 8'h23; mem64[3] = 8'h00;
    start_at64(16'd0);
    wait_valid64(10);
    checks++; if (icode64 !== 4'h1 || valp64 !== 16'd1) begin errors++; $display("FAIL auto_nop: icode=%h valp=%0d expected 1 1", icode64, valp64); end
    checks++; if (ra64 !== 4'hF || valc64 !== 64'd0) begin errors++; $display("FAIL auto_nop_unfetched: rA=%h valC=%h expected f 0", ra64, valc64); end
    accept64();
    checks++; if (valid64 !== 1'b0 || mem_rd64 !== 1'b1 || mem_addr64 !== 16'd1) begin errors++; $display("FAIL auto_advance_rd: valid=%b rd=%b addr=%0d expected 0 1 1", valid64, mem_rd64, mem_addr64); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (valid64 !== 1'b0) begin errors++; $display("FAIL auto_addq_early: instr_valid=%b expected 0", valid64); end
    @(posedge clk); #1;
    checks++; if (valid64 !== 1'b1) begin errors++; $display("FAIL auto_addq_latency: instr_valid=%b expected 1", valid64); end
    checks++; if ({icode64, ifun64, ra64, rb64} !== 16'h6023 || valp64 !== 16'd3) begin errors++; $display("FAIL auto_addq: got %h valp=%0d expected 6023 3", {icode64, ifun64, ra64, rb64}, valp64); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (valid64 !== 1'b1 || mem_rd64 !== 1'b0 || {icode64, ifun64, ra64, rb64} !== 16'h6023 || valp64 !== 16'd3) begin
        errors++; $display("FAIL stall_hold_%0d: valid=%b rd=%b fields=%h valp=%0d expected 1 0 6023 3", i, valid64, mem_rd64, {icode64, ifun64, ra64, rb64}, valp64);
      end
    end
    accept64();
    checks++; if (mem_rd64 !== 1'b1 || mem_addr64 !== 16'd3) begin errors++; $display("FAIL stall_accept_adv: rd=%b addr=%0d expected 1 3", mem_rd64, mem_addr64); end
    wait_valid64(10);
    checks++; if (icode64 !== 4'h0 || valp64 !== 16'd4) begin errors++; $display("FAIL auto_halt: icode=%h valp=%0d expected 0 4", icode64, valp64); end
    accept64();
    checks++; if (busy64 !== 1'b0 || valid64 !== 1'b0) begin errors++; $display("FAIL auto_halt_idle: busy=%b valid=%b expected 0 0", busy64, valid64); end
  endtask

  task automatic test_errors();
    mem64[0] = 8'hC0;
    start_at64(16'd0);
    wait_valid64(10);
    checks++; if (ierr64 !== 1'b1 || valp64 !== 16'd1) begin errors++; $display("FAIL bad_icode: instr_err=%b valp=%0d expected 1 1", ierr64, valp64); end
    checks++; if (icode64 !== 4'hC || ra64 !== 4'hF || rb64 !== 4'hF || valc64 !== 64'd0) begin errors++; $display("FAIL bad_icode_fields: icode=%h rA=%h rB=%h valC=%h expected c f f 0", icode64, ra64, rb64, valc64); end
    accept64();
    checks++; if (busy64 !== 1'b0) begin errors++; $display("FAIL bad_icode_idle: busy=%b expected 0", busy64); end
    mem64[1023] = 8'h30;
    start_at64(16'd1023);
    wait_valid64(10);
    checks++; if (merr64 !== 1'b1 || ierr64 !== 1'b0) begin errors++; $display("FAIL imem_err: imem_err=%b instr_err=%b expected 1 0", merr64, ierr64); end
    checks++; if ({icode64, ifun64, ra64, rb64} !== 16'h10FF || valp64 !== 16'd1023 || valc64 !== 64'd0) begin errors++; $display("FAIL imem_fields: got %h valp=%0d valC=%h expected 10ff 1023 0", {icode64, ifun64, ra64, rb64}, valp64, valc64); end
    checks++; if (oob64 !== 0) begin errors++; $display("FAIL imem_oob_reads: got %0d expected 0", oob64); end
    accept64();
    checks++; if (busy64 !== 1'b0) begin errors++; $display("FAIL imem_idle: busy=%b expected 0", busy64); end
  endtask

  task automatic test_reset_mid();
    mem64[0] = 8'h30; mem64[1] = 8'hF2; mem64[2] = 8'h08;
    for (int i = 3; i < 10; i++) mem64[i] = 8'h00;
    start_at64(16'd0);
    repeat (9) @(posedge clk);
    #1;
    checks++; if (busy64 !== 1'b1 || mem_rd64 !== 1'b0) begin errors++; $display("FAIL mid_cap_state: busy=%b rd=%b expected 1 0", busy64, mem_rd64); end
    rst = 1'b1; ready64 = 1'b1; start64 = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; ready64 = 1'b0; start64 = 1'b0;
    checks++; if (busy64 !== 1'b0 || valid64 !== 1'b0 || mem_rd64 !== 1'b0) begin errors++; $display("FAIL mid_reset_ctl: busy=%b valid=%b rd=%b expected 000", busy64, valid64, mem_rd64); end
    checks++; if ({icode64, ifun64, ra64, rb64} !== 16'h00FF || valc64 !== 64'd0 || valp64 !== 16'd0) begin errors++; $display("FAIL mid_reset_fields: got %h valC=%h valp=%0d expected 00ff 0 0", {icode64, ifun64, ra64, rb64}, valc64, valp64); end
    mem64[20] = 8'h10; mem64[21] = 8'h00;
    start_at64(16'd20);
    wait_valid64(10);
    checks++; if (icode64 !== 4'h1 || valp64 !== 16'd21 || ra64 !== 4'hF || valc64 !== 64'd0) begin errors++; $display("FAIL post_reset_nop: icode=%h valp=%0d rA=%h valC=%h expected 1 21 f 0", icode64, valp64, ra64, valc64); end
    accept64();
    wait_valid64(10);
    checks++; if (icode64 !== 4'h0 || valp64 !== 16'd22) begin errors++; $display("FAIL post_reset_halt: icode=%h valp=%0d expected 0 22", icode64, valp64); end
    accept64();
    checks++; if (busy64 !== 1'b0) begin errors++; $display("FAIL post_reset_idle: busy=%b expected 0", busy64); end
  endtask

  task automatic test_dw32_call();
    mem32[256] = 8'h80; mem32[257] = 8'h00; mem32[258] = 8'h80; mem32[259] = 8'h00; mem32[260] = 8'h00;
    mem32[0] = 8'h00;
    start32 = 1'b1; pc_in32 = 16'h0100;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start32 = 1'b1; pc_in32 = 16'h0000;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (valid32 !== 1'b0) begin errors++; $display("FAIL call32_early: instr_valid=%b at cycle 10 expected 0", valid32); end
    @(posedge clk); #1;
    checks++; if (valid32 !== 1'b1) begin errors++; $display("FAIL call32_latency: instr_valid=%b at cycle 11 expected 1", valid32); end
    checks++; if ({icode32, ifun32, ra32, rb32} !== 16'h80FF) begin errors++; $display("FAIL call32_fields: got %h expected 80ff", {icode32, ifun32, ra32, rb32}); end
    checks++; if (valc32 !== 32'h0000_8000 || valp32 !== 16'h0105) begin errors++; $display("FAIL call32_valc_valp: got %h %h expected 00008000 0105", valc32, valp32); end
    ready32 = 1'b1;
    @(posedge clk); #1;
    ready32 = 1'b0;
    checks++; if (busy32 !== 1'b0 || valid32 !== 1'b0 || mem_rd32 !== 1'b0) begin errors++; $display("FAIL call32_noauto_idle: busy=%b valid=%b rd=%b expected 000", busy32, valid32, mem_rd32); end
  endtask

  initial begin
    rst = 1'b1;
    start64 = 1'b0; pc_in64 = '0; ready64 = 1'b0;
    start32 = 1'b0; pc_in32 = '0; ready32 = 1'b0;
    for (int i = 0; i < 1024; i++) begin mem64[i] = 8'h00; mem32[i] = 8'h00; end
    test_reset();
    test_irmovq();
    test_auto_stream();
    test_errors();
    test_reset_mid();
    test_dw32_call();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
